// File: rtl/kms_receiver.sv
// KMS link receiver: 2-flop synchronized serial input, decodes 40-bit data
// frames and audio-sample-request frames into parallel words and strobes.
module kms_receiver #(
    parameter int BIT_CLKS  = 4,
    parameter int DATA_BITS = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 audio_req_tick,
    output logic                 audio_req_underrun,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int HW = $clog2(BIT_CLKS + 1);

    localparam logic [CW-1:0] CELL_MID  = CW'(BIT_CLKS / 2);
    localparam logic [CW-1:0] CELL_LAST = CW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [HW-1:0] ARM_LAST  = HW'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_DATA,
        S_UFLAG,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic                 sync1, s, s_d;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pend_u;
    logic                 is_data;
    logic                 armed;
    logic [HW-1:0]        high_cnt;

    logic mid, fall;
    logic cnt_clr, bit_clr, shift_en, flag_en, type_en, good_stop, bad_stop;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        flag_en   = 1'b0;
        type_en   = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        mid       = (cnt == CELL_MID);
        fall      = s_d & ~s;
        case (state)
            S_IDLE: begin
                if (fall && armed) begin
                    state_nxt = S_START;
                    cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (mid) state_nxt = s ? S_IDLE : S_TYPE;
            end
            S_TYPE: begin
                if (mid) begin
                    type_en   = 1'b1;
                    bit_clr   = s;
                    state_nxt = s ? S_DATA : S_UFLAG;
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) state_nxt = S_STOP;
                end
            end
            S_UFLAG: begin
                if (mid) begin
                    flag_en   = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    good_stop = s;
                    bad_stop  = ~s;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1              <= 1'b1;
            s                  <= 1'b1;
            s_d                <= 1'b1;
            cnt                <= '0;
            bit_cnt            <= '0;
            shreg              <= '0;
            pend_u             <= 1'b0;
            is_data            <= 1'b0;
            armed              <= 1'b0;
            high_cnt           <= '0;
            data               <= '0;
            data_valid         <= 1'b0;
            audio_req_tick     <= 1'b0;
            audio_req_underrun <= 1'b0;
            frame_error        <= 1'b0;
        end else begin
            sync1 <= sin;
            s     <= sync1;
            s_d   <= s;

            if (cnt_clr || cnt == CELL_LAST) cnt <= '0;
            else                             cnt <= cnt + 1'b1;

            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shreg   <= {shreg[DATA_BITS-2:0], s};
            if (flag_en)  pend_u  <= s;
            if (type_en)  is_data <= s;

            data_valid     <= good_stop & is_data;
            audio_req_tick <= good_stop & ~is_data;
            frame_error    <= bad_stop;
            if (good_stop && is_data)  data               <= shreg;
            if (good_stop && !is_data) audio_req_underrun <= pend_u;

            // After a bad stop (or reset) the line must idle high for a full
            // cell before a falling edge is trusted as a start bit again.
            if (bad_stop) begin
                armed    <= 1'b0;
                high_cnt <= '0;
            end else if (!armed) begin
                if (!s)                        high_cnt <= '0;
                else if (high_cnt == ARM_LAST) armed    <= 1'b1;
                else                           high_cnt <= high_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kms_receiver.sv
// Directed bench for kms_receiver: data/request frames, back-to-back, glitch,
// framing error with re-arm, stuck-low line and mid-frame reset.
module tb_kms_receiver;

    localparam int BIT_CLKS  = 4;
    localparam int DATA_BITS = 40;
    // Logic edge of the stop-bit sample relative to the edge after which the
    // start bit is driven: 1 (first raw sample) + 42 cells + half a cell + 3.
    localparam int DV_OFFSET = 1 + BIT_CLKS * (DATA_BITS + 2) + BIT_CLKS / 2 + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sin;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 audio_req_tick;
    logic                 audio_req_underrun;
    logic                 frame_error;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    kms_receiver #(.BIT_CLKS(BIT_CLKS), .DATA_BITS(DATA_BITS)) dut (
        .clk               (clk),
        .rst               (rst),
        .sin               (sin),
        .data              (data),
        .data_valid        (data_valid),
        .audio_req_tick    (audio_req_tick),
        .audio_req_underrun(audio_req_underrun),
        .frame_error       (frame_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every pulse away from the active edge.
    logic [DATA_BITS-1:0] got_q[$];
    logic                 und_q[$];
    int dv_cnt = 0, tick_cnt = 0, err_cnt = 0, busy_cnt = 0, excl_viol = 0;
    int dv_cyc = -1;
    logic dv_p = 1'b0, tk_p = 1'b0, er_p = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(data);
            dv_cnt++;
            dv_cyc = cyc;
        end
        if (audio_req_tick) begin
            und_q.push_back(audio_req_underrun);
            tick_cnt++;
        end
        if (frame_error) err_cnt++;
        if (busy) busy_cnt++;
        if ((int'(data_valid) + int'(audio_req_tick) + int'(frame_error)) > 1) excl_viol++;
        if ((data_valid && dv_p) || (audio_req_tick && tk_p) || (frame_error && er_p)) excl_viol++;
        dv_p = data_valid;
        tk_p = audio_req_tick;
        er_p = frame_error;
    end

    // Drivers: every task starts and ends 1 ns after a rising edge.
    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sin = v[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [DATA_BITS-1:0] p);
        send_bits({21'h0, 1'b0, 1'b1, p, 1'b1}, DATA_BITS + 3);
    endtask

    task automatic send_req(input logic u);
        send_bits({60'h0, 1'b0, 1'b0, u, 1'b1}, 4);
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", data);
        end
        n_tests++;
        if ({data_valid, audio_req_tick, audio_req_underrun, frame_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {data_valid, audio_req_tick, audio_req_underrun, frame_error});
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_data_frame;
        int base, dvb, bb, p;
        logic [DATA_BITS-1:0] exp_q[$];
        exp_q.push_back(40'hD999999991);
        base = got_q.size();
        dvb  = dv_cnt;
        bb   = busy_cnt;
        p    = cyc;
        send_data(40'hD999999991);
        idle(8);
        n_tests++;
        if (dv_cnt - dvb != 1) begin
            n_fail++;
            $display("FAIL data_pulse_count: got %0d expected 1", dv_cnt - dvb);
        end
        n_tests++;
        if (got_q.size() <= base || got_q[base] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL data_word: got %h expected %h",
                     (got_q.size() > base) ? got_q[base] : 'x, exp_q[0]);
        end
        n_tests++;
        if (dv_cyc != p + DV_OFFSET) begin
            n_fail++;
            $display("FAIL data_latency: got cycle %0d expected %0d", dv_cyc, p + DV_OFFSET);
        end
        n_tests++;
        if (busy !== 1'b0 || busy_cnt - bb < BIT_CLKS * (DATA_BITS + 2)) begin
            n_fail++;
            $display("FAIL data_busy: got busy=%b busy_cycles=%0d expected 0 and >= %0d",
                     busy, busy_cnt - bb, BIT_CLKS * (DATA_BITS + 2));
        end
    endtask

    task automatic test_requests;
        int tb0, ub, dvb;
        tb0 = tick_cnt;
        ub  = und_q.size();
        dvb = dv_cnt;
        send_req(1'b1);
        idle(6);
        n_tests++;
        if (audio_req_underrun !== 1'b1 || tick_cnt - tb0 != 1) begin
            n_fail++;
            $display("FAIL req_u1: got underrun=%b ticks=%0d expected 1 and 1",
                     audio_req_underrun, tick_cnt - tb0);
        end
        send_req(1'b0);
        idle(6);
        n_tests++;
        if (audio_req_underrun !== 1'b0 || tick_cnt - tb0 != 2) begin
            n_fail++;
            $display("FAIL req_u0: got underrun=%b ticks=%0d expected 0 and 2",
                     audio_req_underrun, tick_cnt - tb0);
        end
        n_tests++;
        if (und_q.size() != ub + 2 || und_q[ub] !== 1'b1 || und_q[ub+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL req_tick_flags: got %0d entries expected 2 entries 1,0", und_q.size() - ub);
        end
        n_tests++;
        if (data !== 40'hD999999991 || dv_cnt != dvb) begin
            n_fail++;
            $display("FAIL req_data_hold: got %h dv=%0d expected d999999991 dv=0", data, dv_cnt - dvb);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [DATA_BITS-1:0] exp_q[$];
        exp_q = '{40'hD999999991, 40'hD999999993, 40'hD999999997};
        base = got_q.size();
        foreach (exp_q[i]) send_data(exp_q[i]);
        idle(8);
        n_tests++;
        if (got_q.size() != base + 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 3", got_q.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h expected %h", i,
                         (got_q.size() > base + i) ? got_q[base+i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int dvb, tkb, erb, base;
        dvb = dv_cnt; tkb = tick_cnt; erb = err_cnt;
        idle(10);
        sin = 1'b0;
        @(posedge clk);
        #1;
        idle(20);
        n_tests++;
        if (dv_cnt != dvb || tick_cnt != tkb || err_cnt != erb) begin
            n_fail++;
            $display("FAIL glitch_quiet: got dv=%0d tick=%0d err=%0d expected 0 0 0",
                     dv_cnt - dvb, tick_cnt - tkb, err_cnt - erb);
        end
        base = got_q.size();
        send_data(40'hA5A50F0F3C);
        idle(8);
        n_tests++;
        if (got_q.size() != base + 1 || got_q[base] !== 40'hA5A50F0F3C) begin
            n_fail++;
            $display("FAIL glitch_next: got %0d words expected 1 word a5a50f0f3c", got_q.size() - base);
        end
    endtask

    task automatic test_frame_error;
        int dvb, erb, base;
        dvb = dv_cnt; erb = err_cnt;
        send_bits({21'h0, 1'b0, 1'b1, 40'h123456789A, 1'b0}, DATA_BITS + 3);
        idle(2);
        sin = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        idle(200);
        n_tests++;
        if (err_cnt - erb != 1) begin
            n_fail++;
            $display("FAIL ferr_pulse: got %0d expected 1", err_cnt - erb);
        end
        n_tests++;
        if (dv_cnt != dvb || data !== 40'hA5A50F0F3C) begin
            n_fail++;
            $display("FAIL ferr_hold: got data=%h dv=%0d expected a5a50f0f3c dv=0", data, dv_cnt - dvb);
        end
        base = got_q.size();
        send_data(40'h0123456789);
        idle(8);
        n_tests++;
        if (got_q.size() != base + 1 || got_q[base] !== 40'h0123456789) begin
            n_fail++;
            $display("FAIL ferr_next: got %0d words data=%h expected 1 word 0123456789",
                     got_q.size() - base, data);
        end
    endtask

    task automatic test_stuck_low;
        int dvb, tkb, erb, base;
        dvb = dv_cnt; tkb = tick_cnt; erb = err_cnt;
        sin = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        n_tests++;
        if (err_cnt - erb != 1 || dv_cnt != dvb || tick_cnt != tkb) begin
            n_fail++;
            $display("FAIL stuck_low: got err=%0d dv=%0d tick=%0d expected 1 0 0",
                     err_cnt - erb, dv_cnt - dvb, tick_cnt - tkb);
        end
        idle(20);
        base = got_q.size();
        send_data(40'hFEDCBA9876);
        idle(8);
        n_tests++;
        if (got_q.size() != base + 1 || got_q[base] !== 40'hFEDCBA9876) begin
            n_fail++;
            $display("FAIL stuck_low_next: got %0d words data=%h expected fedcba9876",
                     got_q.size() - base, data);
        end
    endtask

    task automatic test_reset_mid;
        int dvb, base;
        logic [63:0] fv;
        dvb = dv_cnt;
        fv  = {21'h0, 1'b0, 1'b1, 40'h5555AAAA33, 1'b1};
        send_bits(fv >> (DATA_BITS + 3 - 12), 12);
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (data !== '0 || busy !== 1'b0 ||
            {data_valid, audio_req_tick, audio_req_underrun, frame_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got data=%h busy=%b flags=%b expected 0 0 0000", data, busy,
                     {data_valid, audio_req_tick, audio_req_underrun, frame_error});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(200);
        n_tests++;
        if (dv_cnt != dvb) begin
            n_fail++;
            $display("FAIL rst_mid_discard: got %0d pulses expected 0", dv_cnt - dvb);
        end
        base = got_q.size();
        send_data(40'h5555AAAA33);
        idle(8);
        n_tests++;
        if (got_q.size() != base + 1 || got_q[base] !== 40'h5555AAAA33) begin
            n_fail++;
            $display("FAIL rst_mid_next: got %0d words data=%h expected 5555aaaa33",
                     got_q.size() - base, data);
        end
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        test_reset;
        test_data_frame;
        test_requests;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_stuck_low;
        test_reset_mid;
        n_tests++;
        if (excl_viol != 0) begin
            n_fail++;
            $display("FAIL pulse_exclusive: got %0d violations expected 0", excl_viol);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
